// File: rtl/mem_access_unit.sv
// Load/store unit: turns one byte/half/word pipeline access into a single word-aligned
// req/ack bus transaction. Optional bus-timeout abort is enabled with `define LSU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic                  op_write,
  input  logic [1:0]            op_type,
  input  logic                  op_signed,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [31:0]           op_wdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [1:0]            resp_code
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_LD_MIS  = 2'd1;
  localparam logic [1:0] CODE_ST_MIS  = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (ADDR_WIDTH < 3) begin : g_bad_addr
    $error("ADDR_WIDTH must be at least 3");
  end

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [3:0]              be_reg, be_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic                    we_reg, we_next;
  logic [1:0]              type_reg, type_next;
  logic [1:0]              lane_reg, lane_next;
  logic                    signed_reg, signed_next;
  logic [31:0]             rdata_reg, rdata_next;
  logic [1:0]              code_reg, code_next;
  logic                    timeout_hit;

  // Per-lane decode of the incoming address and the returning read word
  logic [3:0] be_onehot;
  logic [7:0] rd_lane [4];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign be_onehot[gi] = (op_addr[1:0] == 2'(gi));
    assign rd_lane[gi]   = bus_rdata[8*gi +: 8];
  end

  logic        misaligned;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    misaligned = 1'b0;
    be_in      = 4'b1111;
    wdata_in   = op_wdata;
    case (op_type)
      2'd0: begin
        be_in    = be_onehot;
        wdata_in = {4{op_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = op_addr[0];
        be_in      = op_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in   = {2{op_wdata[15:0]}};
      end
      default: misaligned = (op_addr[1:0] != 2'b00);
    endcase
  end

  // Lane extraction uses the captured access, never the live op_* inputs
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    byte_sel  = rd_lane[lane_reg];
    half_sel  = lane_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (type_reg)
      2'd0:    load_data = {{24{signed_reg & byte_sel[7]}}, byte_sel};
      2'd1:    load_data = {{16{signed_reg & half_sel[15]}}, half_sel};
      default: load_data = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = '0;
    if (state_reg == BUS) cnt_next = cnt_reg + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end

  // Fires on the edge that ends the TIMEOUT_CYCLES-th BUS cycle
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    be_next     = be_reg;
    wdata_next  = wdata_reg;
    we_next     = we_reg;
    type_next   = type_reg;
    lane_next   = lane_reg;
    signed_next = signed_reg;
    rdata_next  = rdata_reg;
    code_next   = code_reg;
    case (state_reg)
      IDLE: begin
        if (op_valid) begin
          we_next     = op_write;
          type_next   = op_type;
          lane_next   = op_addr[1:0];
          signed_next = op_signed;
          rdata_next  = '0;
          if (misaligned) begin
            code_next  = op_write ? CODE_ST_MIS : CODE_LD_MIS;
            state_next = RESP;
          end else begin
            addr_next  = {op_addr[ADDR_WIDTH-1:2], 2'b00};
            be_next    = be_in;
            wdata_next = wdata_in;
            code_next  = CODE_NONE;
            state_next = BUS;
          end
        end
      end
      BUS: begin
        // Ack takes priority over a timeout on the same edge
        if (bus_ack) begin
          rdata_next = we_reg ? 32'd0 : load_data;
          code_next  = CODE_NONE;
          state_next = RESP;
        end else if (timeout_hit) begin
          rdata_next = '0;
          code_next  = CODE_TIMEOUT;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      be_reg     <= '0;
      wdata_reg  <= '0;
      we_reg     <= 1'b0;
      type_reg   <= '0;
      lane_reg   <= '0;
      signed_reg <= 1'b0;
      rdata_reg  <= '0;
      code_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      be_reg     <= be_next;
      wdata_reg  <= wdata_next;
      we_reg     <= we_next;
      type_reg   <= type_next;
      lane_reg   <= lane_next;
      signed_reg <= signed_next;
      rdata_reg  <= rdata_next;
      code_reg   <= code_next;
    end
  end

  assign op_ready   = (state_reg == IDLE);
  assign bus_req    = (state_reg == BUS);
  assign bus_we     = bus_req & we_reg;
  assign bus_addr   = addr_reg;
  assign bus_be     = be_reg;
  assign bus_wdata  = wdata_reg;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_valid ? rdata_reg : 32'd0;
  assign resp_fault = resp_valid & (code_reg != CODE_NONE);
  assign resp_code  = resp_valid ? code_reg : CODE_NONE;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against an arithmetic reference model.
// Timeout expectations follow whether LSU_TIMEOUT_EN is defined for the build.
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid, op_ready, op_write, op_signed;
  logic [1:0]    op_type;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic          bus_req, bus_we, bus_ack;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata, bus_rdata;
  logic          resp_valid, resp_fault;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_code;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_write(op_write),
    .op_type(op_type), .op_signed(op_signed), .op_addr(op_addr), .op_wdata(op_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_code(resp_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: access size in bytes, reserved type 3 behaves as a word
  function automatic int ref_size(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] t, input logic [31:0] a);
    return (a % ref_size(t)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] t, input logic [31:0] a);
    int mask;
    mask = ((1 << ref_size(t)) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] t, input logic [31:0] w);
    if (t == 2'd0) return {24'd0, w[7:0]} * 32'h0101_0101;
    if (t == 2'd1) return {16'd0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] t, input logic s,
                                           input logic [31:0] a, input logic [31:0] rd);
    longint bits, v;
    if (ref_size(t) == 4) return rd;
    bits = 8 * ref_size(t);
    v = longint'(rd >> (8 * (a % 4))) & ((longint'(1) << bits) - 1);
    if (s && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // One complete access; starts and ends at a falling edge with the unit idle
  task automatic run_op(input string tag, input logic w, input logic [1:0] t, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int waitc, input bit hold);
    int  exp_cycles;
    bit  timed_out;
    check({tag, ".ready"}, 32'(op_ready), 32'd1);
    op_valid  = 1'b1;
    op_write  = w;
    op_type   = t;
    op_signed = s;
    op_addr   = a;
    op_wdata  = wd;
    bus_ack   = 1'($urandom_range(0, 1));
    @(posedge clk); @(negedge clk);
    if (!hold) begin
      op_valid  = 1'b0;
      op_write  = 1'($urandom);
      op_type   = 2'($urandom);
      op_signed = 1'($urandom);
      op_addr   = $urandom;
      op_wdata  = $urandom;
    end
    bus_ack = 1'b0;
    if (ref_misaligned(t, a)) begin
      check({tag, ".mis_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".mis_fault"}, 32'(resp_fault), 32'd1);
      check({tag, ".mis_code"},  32'(resp_code), w ? 32'd2 : 32'd1);
      check({tag, ".mis_rdata"}, resp_rdata, 32'd0);
      check({tag, ".mis_req"},   32'(bus_req), 32'd0);
    end else begin
      timed_out  = TO_EN && (waitc >= TO);
      exp_cycles = timed_out ? TO : waitc + 1;
      for (int n = 0; n < exp_cycles; n++) begin
        check({tag, ".req"},   32'(bus_req), 32'd1);
        check({tag, ".we"},    32'(bus_we), 32'(w));
        check({tag, ".addr"},  bus_addr, a & ~32'd3);
        check({tag, ".be"},    32'(bus_be), 32'(ref_be(t, a)));
        check({tag, ".wdata"}, bus_wdata, ref_wdata(t, wd));
        check({tag, ".busy"},  32'({op_ready, resp_valid}), 32'd0);
        bus_ack   = (n == waitc);
        bus_rdata = (n == waitc) ? rd : $urandom;
        @(posedge clk); @(negedge clk);
      end
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      check({tag, ".valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".fault"}, 32'(resp_fault), 32'(timed_out));
      check({tag, ".code"},  32'(resp_code), timed_out ? 32'd3 : 32'd0);
      check({tag, ".rdata"}, resp_rdata, (w || timed_out) ? 32'd0 : ref_load(t, s, a, rd));
      check({tag, ".req_drop"}, 32'(bus_req), 32'd0);
    end
    check({tag, ".ready_resp"}, 32'(op_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    check({tag, ".idle"}, 32'({resp_valid, bus_req, op_ready}), 32'b001);
    bus_ack = 1'b0;
    $display("op %-10s we=%0d type=%0d sgn=%0d addr=0x%08h wait=%0d", tag, w, t, s, a, waitc);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_write = 1'b0; op_type = 2'd0; op_signed = 1'b0;
    op_addr = '0; op_wdata = '0; bus_ack = 1'b1; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(op_ready), 32'd1);
    check("rst.bus",   32'({bus_req, bus_we, bus_be}), 32'd0);
    check("rst.addr",  bus_addr, 32'd0);
    check("rst.wdata", bus_wdata, 32'd0);
    check("rst.resp",  32'({resp_valid, resp_fault, resp_code}), 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    reset = 1'b0; bus_ack = 1'b0;
    @(posedge clk); @(negedge clk);

    // Directed accesses
    run_op("st_b",    1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 0, 1'b0);
    run_op("ld_h_s",  1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 2, 1'b0);
    run_op("ld_h_u",  1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 2, 1'b0);
    run_op("ld_w_mis",1'b0, 2'd2, 1'b0, 32'h0006, 32'h0, 32'h0, 0, 1'b0);
    run_op("st_h_mis",1'b1, 2'd1, 1'b0, 32'h0005, 32'h1234, 32'h0, 0, 1'b0);
    run_op("held1",   1'b0, 2'd0, 1'b0, 32'h0001, 32'h0, 32'h0000_9C00, 1, 1'b1);
    run_op("held2",   1'b0, 2'd0, 1'b0, 32'h0001, 32'h0, 32'h0000_9C00, 0, 1'b0);
    run_op("ld_b_s",  1'b0, 2'd0, 1'b1, 32'h0002, 32'h0, 32'h0080_0000, 0, 1'b0);
    run_op("st_w_t3", 1'b1, 2'd3, 1'b0, 32'h0010, 32'hDEAD_BEEF, 32'h0, 1, 1'b0);
    run_op("ack4th",  1'b0, 2'd2, 1'b0, 32'h0020, 32'h0, 32'h1357_9BDF, TO - 1, 1'b0);
    run_op("no_ack",  1'b0, 2'd2, 1'b0, 32'h0024, 32'h0, 32'h2468_ACE0, TO + 2, 1'b0);

    // Reset in the second BUS cycle, then a late ack must not produce a response
    op_valid = 1'b1; op_write = 1'b0; op_type = 2'd2; op_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0; bus_ack = 1'b0;
    check("rstmid.req1", 32'(bus_req), 32'd1);
    @(posedge clk); @(negedge clk);
    check("rstmid.req2", 32'(bus_req), 32'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("rstmid.req0",  32'(bus_req), 32'd0);
    check("rstmid.ready", 32'(op_ready), 32'd1);
    bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("rstmid.noresp", 32'({resp_valid, bus_req}), 32'd0);
    end
    bus_ack = 1'b0;
    $display("op reset_mid  load word addr=0x00000040 reset in 2nd BUS cycle");

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      run_op("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom,
             int'($urandom_range(0, TO + 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
